imem_port_arbiter: RTL and testbench

- Shares the single data-bus port of the instruction memory between two requesters: port 0, the CPU data bus, and port 1, the external loader/debug bus.
- Each requester issues one-cycle strobes. The arbiter buffers one pending transaction per port and grants the memory port round-robin or fixed-priority.
- It issues a one-cycle memory request, waits for the memory ack, and returns the registered read data plus a one-cycle ack to the winning requester.

---
 rtl/imem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the instruction memory's single data-bus port
// between the CPU data bus (port 0) and the external loader/debug bus (port 1).
//
// Each port may hold one buffered transaction. An idle arbiter grants a
// pending port and issues a one-cycle mem_request from registered mem_*
// outputs. It then waits for mem_ack and returns the read data to the winner,
// together with a one-cycle ack.
//
// Ports:
//   clock, reset                    rising-edge clock, async active-high reset
//   cpu_* / ext_*                   requester side: request, address, write,
//                                   wstrb, wdata in; rdata, ack, busy out
//   mem_request/address/write/      registered memory request; only
//   wstrb/wdata                     mem_request pulses
//   mem_rdata, mem_ack              memory response, one cycle after request
//
// States:
//   state  | meaning
//   IDLE   | no memory access in flight; grant a pending port if any
//   WAIT   | request issued; waiting for mem_ack for winner_q
`timescale 1ns/1ps
module imem_port_arbiter #(
  parameter int ADDR_WIDTH     = 16,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_request,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_write,
  input  logic [3:0]            cpu_wstrb,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_busy,
  input  logic                  ext_request,
  input  logic [ADDR_WIDTH-1:0] ext_address,
  input  logic                  ext_write,
  input  logic [3:0]            ext_wstrb,
  input  logic [31:0]           ext_wdata,
  output logic [31:0]           ext_rdata,
  output logic                  ext_ack,
  output logic                  ext_busy,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  output logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t state_q, state_d;

  logic                  req      [2];
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic                  req_wr   [2];
  logic [3:0]            req_strb [2];
  logic [31:0]           req_data [2];

  logic [1:0]            pend_q;
  logic [ADDR_WIDTH-1:0] addr_q   [2];
  logic                  wr_q     [2];
  logic [3:0]            strb_q   [2];
  logic [31:0]           data_q   [2];

  logic                  winner_q;
  logic                  last_grant_q;
  logic                  grant;
  logic                  do_grant;
  logic                  do_ack;

  logic                  mem_request_q;
  logic [ADDR_WIDTH-1:0] mem_address_q;
  logic                  mem_write_q;
  logic [3:0]            mem_wstrb_q;
  logic [31:0]           mem_wdata_q;
  logic [31:0]           cpu_rdata_q, ext_rdata_q;
  logic                  cpu_ack_q, ext_ack_q;

  assign req[0]      = cpu_request;
  assign req[1]      = ext_request;
  assign req_addr[0] = cpu_address;
  assign req_addr[1] = ext_address;
  assign req_wr[0]   = cpu_write;
  assign req_wr[1]   = ext_write;
  assign req_strb[0] = cpu_wstrb;
  assign req_strb[1] = ext_wstrb;
  assign req_data[0] = cpu_wdata;
  assign req_data[1] = ext_wdata;

  always_comb begin
    state_d  = state_q;
    grant    = winner_q;
    do_grant = 1'b0;
    do_ack   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pend_q != 2'b00) begin
          do_grant = 1'b1;
          state_d  = S_WAIT;
          if (FIXED_PRIORITY)
            grant = ~pend_q[0];
          else if (pend_q == 2'b11)
            grant = ~last_grant_q;   // contest: the port not served last wins
          else
            grant = ~pend_q[0];
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          do_ack  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pend_q        <= 2'b00;
      winner_q      <= 1'b0;
      last_grant_q  <= 1'b1;
      mem_request_q <= 1'b0;
      mem_address_q <= '0;
      mem_write_q   <= 1'b0;
      mem_wstrb_q   <= 4'h0;
      mem_wdata_q   <= 32'h0;
      cpu_rdata_q   <= 32'h0;
      ext_rdata_q   <= 32'h0;
      cpu_ack_q     <= 1'b0;
      ext_ack_q     <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        addr_q[p] <= '0;
        wr_q[p]   <= 1'b0;
        strb_q[p] <= 4'h0;
        data_q[p] <= 32'h0;
      end
    end else begin
      state_q       <= state_d;
      mem_request_q <= do_grant;
      cpu_ack_q     <= do_ack && !winner_q;
      ext_ack_q     <= do_ack && winner_q;

      if (do_grant) begin
        winner_q      <= grant;
        mem_address_q <= addr_q[grant];
        mem_write_q   <= wr_q[grant];
        mem_wstrb_q   <= strb_q[grant];
        mem_wdata_q   <= data_q[grant];
      end

      if (do_ack) begin
        last_grant_q <= winner_q;
        if (winner_q) ext_rdata_q <= mem_rdata;
        else          cpu_rdata_q <= mem_rdata;
      end

      // A strobe while the buffer is occupied is dropped; the buffer being
      // retired by an ack is still occupied at this edge, so no overlap.
      for (int p = 0; p < 2; p++) begin
        if (do_ack && (winner_q == p[0])) begin
          pend_q[p] <= 1'b0;
        end else if (req[p] && !pend_q[p]) begin
          pend_q[p] <= 1'b1;
          addr_q[p] <= req_addr[p];
          wr_q[p]   <= req_wr[p];
          strb_q[p] <= req_strb[p];
          data_q[p] <= req_data[p];
        end
      end
    end
  end

  assign cpu_busy    = pend_q[0];
  assign ext_busy    = pend_q[1];
  assign cpu_ack     = cpu_ack_q;
  assign ext_ack     = ext_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign ext_rdata   = ext_rdata_q;
  assign mem_request = mem_request_q;
  assign mem_address = mem_address_q;
  assign mem_write   = mem_write_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
`timescale 1ns/1ps
module tb_imem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_request, cpu_write, ext_request, ext_write;
  logic [15:0] cpu_address, ext_address;
  logic [3:0]  cpu_wstrb, ext_wstrb;
  logic [31:0] cpu_wdata, ext_wdata;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        cpu_ack, ext_ack, cpu_busy, ext_busy;
  logic        mem_request, mem_write;
  logic [15:0] mem_address;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;

  logic [31:0] cpu_rdata_fp, ext_rdata_fp;
  logic        cpu_ack_fp, ext_ack_fp, cpu_busy_fp, ext_busy_fp;
  logic        mem_request_fp, mem_write_fp;
  logic [15:0] mem_address_fp;
  logic [3:0]  mem_wstrb_fp;
  logic [31:0] mem_wdata_fp;

  logic        auto_ack = 1'b0;
  logic        manual_ack = 1'b0;
  logic        resp_en = 1'b1;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  assign mem_ack = auto_ack | manual_ack;

  // memory model: acks the cycle after each request with rd_val
  always @(posedge clock) begin
    auto_ack <= mem_request && resp_en;
    if (mem_request && resp_en) mem_rdata <= rd_val;
  end

  imem_port_arbiter #(.ADDR_WIDTH(16), .FIXED_PRIORITY(1'b0)) dut (
    .clock(clock), .reset(reset),
    .cpu_request(cpu_request), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .ext_request(ext_request), .ext_address(ext_address), .ext_write(ext_write),
    .ext_wstrb(ext_wstrb), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
    .ext_ack(ext_ack), .ext_busy(ext_busy),
    .mem_request(mem_request), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  imem_port_arbiter #(.ADDR_WIDTH(16), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clock(clock), .reset(reset),
    .cpu_request(cpu_request), .cpu_address(cpu_address), .cpu_write(cpu_write),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata_fp),
    .cpu_ack(cpu_ack_fp), .cpu_busy(cpu_busy_fp),
    .ext_request(ext_request), .ext_address(ext_address), .ext_write(ext_write),
    .ext_wstrb(ext_wstrb), .ext_wdata(ext_wdata), .ext_rdata(ext_rdata_fp),
    .ext_ack(ext_ack_fp), .ext_busy(ext_busy_fp),
    .mem_request(mem_request_fp), .mem_address(mem_address_fp), .mem_write(mem_write_fp),
    .mem_wstrb(mem_wstrb_fp), .mem_wdata(mem_wdata_fp), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_request = 1'b0; cpu_address = 16'h0; cpu_write = 1'b0;
    cpu_wstrb = 4'h0; cpu_wdata = 32'h0;
    ext_request = 1'b0; ext_address = 16'h0; ext_write = 1'b0;
    ext_wstrb = 4'h0; ext_wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    manual_ack = 1'b0;
    resp_en = 1'b1;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic cpu_read(input logic [15:0] a);
    cpu_request = 1'b1; cpu_address = a; cpu_write = 1'b0; cpu_wstrb = 4'h0;
  endtask

  task automatic ext_read(input logic [15:0] a);
    ext_request = 1'b1; ext_address = a; ext_write = 1'b0; ext_wstrb = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    vectors++;
    if ({cpu_ack, ext_ack, cpu_busy, ext_busy, mem_request} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 00000",
               {cpu_ack, ext_ack, cpu_busy, ext_busy, mem_request});
    end
    vectors++;
    if (mem_address !== 16'h0 || mem_wdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mem_regs: got addr %h wdata %h expected 0", mem_address, mem_wdata);
    end
    vectors++;
    if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h expected 0", cpu_rdata, ext_rdata);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    do_reset();
    rd_val = 32'hDEADBEEF;
    cpu_read(16'h0010);
    step();
    idle_inputs();
    for (int k = 1; k <= 5; k++) begin
      vectors++;
      if (cpu_busy !== (k <= 3) || cpu_ack !== (k == 4) || mem_request !== (k == 2)) begin
        miscompares++;
        $display("FAIL single_read c%0d: got busy/ack/req %b%b%b expected %b%b%b", k,
                 cpu_busy, cpu_ack, mem_request, k <= 3, k == 4, k == 2);
      end
      if (k == 2) begin
        vectors++;
        if (mem_address !== 16'h0010 || mem_write !== 1'b0) begin
          miscompares++;
          $display("FAIL single_read_addr: got %h/%b expected 0010/0", mem_address, mem_write);
        end
      end
      if (k == 4) begin
        vectors++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
          miscompares++;
          $display("FAIL single_read_rdata: got %h expected deadbeef", cpu_rdata);
        end
      end
      step();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cpu_request = 1'b1; cpu_address = 16'h0020; cpu_write = 1'b1;
    cpu_wstrb = 4'hF; cpu_wdata = 32'h11111111;
    ext_request = 1'b1; ext_address = 16'h0024; ext_write = 1'b1;
    ext_wstrb = 4'hF; ext_wdata = 32'h22222222;
    step();
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      vectors++;
      if (mem_request !== (k == 2 || k == 5) || cpu_ack !== (k == 4) || ext_ack !== (k == 7)) begin
        miscompares++;
        $display("FAIL simul c%0d: got req/cack/eack %b%b%b expected %b%b%b", k,
                 mem_request, cpu_ack, ext_ack, k == 2 || k == 5, k == 4, k == 7);
      end
      if (k == 2) begin
        vectors++;
        if (mem_address !== 16'h0020 || mem_wdata !== 32'h11111111 ||
            mem_write !== 1'b1 || mem_wstrb !== 4'hF) begin
          miscompares++;
          $display("FAIL simul_first: got %h %h %b %h expected 0020 11111111 1 f",
                   mem_address, mem_wdata, mem_write, mem_wstrb);
        end
      end
      if (k == 5) begin
        vectors++;
        if (mem_address !== 16'h0024 || mem_wdata !== 32'h22222222) begin
          miscompares++;
          $display("FAIL simul_second: got %h %h expected 0024 22222222", mem_address, mem_wdata);
        end
      end
      step();
    end
  endtask

  task automatic test_round_robin();
    int grants[8];
    int ngrant = 0, cpu_n = 1, ext_n = 1, cpu_acks = 0, ext_acks = 0;
    logic [15:0] a;
    do_reset();
    cpu_read(16'h0100);
    ext_read(16'h0200);
    step();
    for (int c = 0; c < 40; c++) begin
      idle_inputs();
      if (mem_request) begin
        a = mem_address;
        if (ngrant < 8) grants[ngrant] = int'(a[9]);
        ngrant++;
      end
      if (cpu_ack) begin
        cpu_acks++;
        if (cpu_n < 3) begin cpu_read(16'h0100 + 16'(4 * cpu_n)); cpu_n++; end
      end
      if (ext_ack) begin
        ext_acks++;
        if (ext_n < 3) begin ext_read(16'h0200 + 16'(4 * ext_n)); ext_n++; end
      end
      step();
    end
    vectors++;
    if (ngrant !== 6 || cpu_acks !== 3 || ext_acks !== 3) begin
      miscompares++;
      $display("FAIL rr_counts: got grants %0d cpu %0d ext %0d expected 6 3 3",
               ngrant, cpu_acks, ext_acks);
    end
    for (int i = 0; i < 6 && i < ngrant; i++) begin
      vectors++;
      if (grants[i] !== i % 2) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got port %0d expected %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    cpu_read(16'h0060);
    step();
    idle_inputs();
    for (int k = 1; k <= 5; k++) step();
    // last grant is now port 0 in both instances
    cpu_read(16'h0064);
    ext_read(16'h0068);
    step();
    idle_inputs();
    step();
    vectors++;
    if (mem_request !== 1'b1 || mem_address !== 16'h0068) begin
      miscompares++;
      $display("FAIL rr_contest: got req %b addr %h expected 1 0068", mem_request, mem_address);
    end
    vectors++;
    if (mem_request_fp !== 1'b1 || mem_address_fp !== 16'h0064) begin
      miscompares++;
      $display("FAIL fp_contest: got req %b addr %h expected 1 0064", mem_request_fp, mem_address_fp);
    end
    step(); step(); step();
    vectors++;
    if (mem_request_fp !== 1'b1 || mem_address_fp !== 16'h0068 || mem_address !== 16'h0064) begin
      miscompares++;
      $display("FAIL fp_second: got fp %b %h rr %h expected 1 0068 0064",
               mem_request_fp, mem_address_fp, mem_address);
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_protocol_violation();
    int reqs = 0, acks = 0, bad_addr = 0;
    do_reset();
    cpu_read(16'h0030);
    step();
    cpu_read(16'h0034);
    step();
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      if (mem_request) begin
        reqs++;
        if (mem_address !== 16'h0030) bad_addr++;
      end
      if (cpu_ack) acks++;
      step();
    end
    vectors++;
    if (reqs !== 1 || acks !== 1 || bad_addr !== 0) begin
      miscompares++;
      $display("FAIL violation: got reqs %0d acks %0d bad_addr %0d expected 1 1 0",
               reqs, acks, bad_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    int stray = 0;
    do_reset();
    resp_en = 1'b0;
    ext_read(16'h0040);
    step();
    idle_inputs();
    step();
    vectors++;
    if (mem_request !== 1'b1 || mem_address !== 16'h0040) begin
      miscompares++;
      $display("FAIL rst_wait_req: got %b %h expected 1 0040", mem_request, mem_address);
    end
    step();
    reset = 1'b1;
    #1;
    vectors++;
    if (ext_busy !== 1'b0 || mem_request !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait_clear: got busy %b req %b expected 0 0", ext_busy, mem_request);
    end
    step();
    reset = 1'b0;
    step();
    manual_ack = 1'b1;
    step();
    manual_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (ext_ack || cpu_ack || ext_busy || cpu_busy || mem_request) stray++;
      step();
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL rst_wait_stray: got %0d active cycles expected 0", stray);
    end
    resp_en = 1'b1;
    rd_val = 32'hCAFEF00D;
    cpu_read(16'h0044);
    step();
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) begin
        vectors++;
        if (mem_request !== 1'b1 || mem_address !== 16'h0044) begin
          miscompares++;
          $display("FAIL rst_wait_after_req: got %b %h expected 1 0044", mem_request, mem_address);
        end
      end
      if (k == 4) begin
        vectors++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hCAFEF00D || ext_ack !== 1'b0) begin
          miscompares++;
          $display("FAIL rst_wait_after_ack: got %b %h %b expected 1 cafef00d 0",
                   cpu_ack, cpu_rdata, ext_ack);
        end
      end
      step();
    end
  endtask

  task automatic test_rdata_isolation();
    do_reset();
    rd_val = 32'hA5A5A5A5;
    ext_read(16'h0050);
    step();
    idle_inputs();
    for (int k = 1; k <= 4; k++) step();
    vectors++;
    if (ext_ack !== 1'b0 || ext_rdata !== 32'hA5A5A5A5 || cpu_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL iso_ext: got ack %b ext %h cpu %h expected 0 a5a5a5a5 0",
               ext_ack, ext_rdata, cpu_rdata);
    end
    rd_val = 32'h5A5A5A5A;
    cpu_read(16'h0054);
    step();
    idle_inputs();
    for (int k = 1; k < 4; k++) step();
    vectors++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h5A5A5A5A || ext_rdata !== 32'hA5A5A5A5) begin
      miscompares++;
      $display("FAIL iso_cpu: got ack %b cpu %h ext %h expected 1 5a5a5a5a a5a5a5a5",
               cpu_ack, cpu_rdata, ext_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_round_robin();
    test_fixed_priority();
    test_protocol_violation();
    test_reset_in_wait();
    test_rdata_isolation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
